// File: rtl/mem_stage_ctrl.sv
// MEM stage and MEM/WB register: req/ack data-memory access with freeze and timeout abort.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are dropped with a mem_err pulse.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [4:0]        Dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              freeze,
  output logic              mem_err,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_read_value,
  output logic [4:0]        Dest
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic              r_wb_en;
  logic              r_mem_r_en;
  logic [31:0]       r_alu;
  logic [31:0]       r_rval;
  logic [4:0]        r_dest;

  logic w_access;
  logic w_load;
  logic w_idle;
  logic w_busy;
  logic w_misalign;
  logic w_bad;
  logic w_issue;
  logic w_ack;
  logic w_tmo;
  logic w_freeze;

  assign w_access = MEM_R_EN_in | MEM_W_EN_in;
  assign w_load   = MEM_R_EN_in & ~MEM_W_EN_in;
  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = (r_state == S_BUSY);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & (ALU_result_in[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad    = w_idle & w_misalign;
  assign w_issue  = w_idle & w_access & ~w_misalign;
  assign w_ack    = w_busy & mem_ack;
  assign w_tmo    = w_busy & ~mem_ack & (r_cnt == LAST);
  assign w_freeze = w_issue | (w_busy & ~mem_ack & ~w_tmo);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_tmo | w_bad;
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_we    <= MEM_W_EN_in;
            r_addr  <= ALU_result_in[ADDR_W+1:2];
            r_wdata <= ST_val_in;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (w_ack | w_tmo) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data goes straight from mem_rdata on the ack cycle; the
  // instruction leaves MEM on that same edge, so no holding copy is needed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_alu      <= '0;
      r_rval     <= '0;
      r_dest     <= '0;
    end else if (w_freeze) begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
    end else begin
      r_wb_en    <= WB_en_in & ~w_tmo & ~w_bad;
      r_mem_r_en <= MEM_R_EN_in;
      r_alu      <= ALU_result_in;
      r_rval     <= (w_ack & w_load) ? mem_rdata : 32'd0;
      r_dest     <= Dest_in;
    end
  end

  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_err        = r_err;
  assign freeze         = w_freeze;
  assign WB_en          = r_wb_en;
  assign MEM_R_EN       = r_mem_r_en;
  assign ALU_result     = r_alu;
  assign MEM_read_value = r_rval;
  assign Dest           = r_dest;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: transaction-level expectation model plus
// a per-cycle compare process and literal spot checks.
module tb_mem_stage_ctrl;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              WB_en_in = 1'b0;
  logic              MEM_R_EN_in = 1'b0;
  logic              MEM_W_EN_in = 1'b0;
  logic [31:0]       ALU_result_in = '0;
  logic [31:0]       ST_val_in = '0;
  logic [4:0]        Dest_in = '0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              freeze;
  logic              mem_err;
  logic              WB_en;
  logic              MEM_R_EN;
  logic [31:0]       ALU_result;
  logic [31:0]       MEM_read_value;
  logic [4:0]        Dest;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
    .MEM_W_EN_in(MEM_W_EN_in), .ALU_result_in(ALU_result_in),
    .ST_val_in(ST_val_in), .Dest_in(Dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .freeze(freeze), .mem_err(mem_err),
    .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
    .MEM_read_value(MEM_read_value), .Dest(Dest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk = 1'b0;

  // expected outputs for the current cycle
  logic              e_frz = 0, e_req = 0, e_err = 0, e_side = 0;
  logic              e_we = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [31:0]       e_wdata = '0;
  logic              e_wben = 0, e_mren = 0;
  logic [31:0]       e_alu = '0, e_rv = '0;
  logic [4:0]        e_dst = '0;

  int frz_seen = 0, req_seen = 0, err_seen = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_wdata = '0;
  logic              last_we = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("freeze", freeze, e_frz);
      check("mem_req", mem_req, e_req);
      check("mem_err", mem_err, e_err);
      check("WB_en", WB_en, e_wben);
      check("MEM_R_EN", MEM_R_EN, e_mren);
      check("ALU_result", ALU_result, e_alu);
      check("MEM_read_value", MEM_read_value, e_rv);
      check("Dest", Dest, e_dst);
      if (e_req | e_side) begin
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
      end
      if (freeze) frz_seen++;
      if (mem_err) err_seen++;
      if (mem_req) begin
        req_seen++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_we    = mem_we;
      end
    end
  end

  // One cycle: declare what this cycle must show, then apply the
  // MEM/WB rules to what the edge closing it must produce.
  task automatic step(input bit frz, input bit req, input bit ack,
                      input bit abort);
    e_frz = frz;
    e_req = req;
    mem_ack = ack;
    @(posedge clk);
    if (!rst) begin
      e_wben = 0; e_mren = 0; e_alu = '0; e_rv = '0; e_dst = '0;
      e_we = 0; e_addr = '0; e_wdata = '0; e_err = 0; e_side = 1;
    end else begin
      e_side = 0;
      if (frz) begin
        e_wben = 0;
        e_mren = 0;
      end else begin
        e_wben = WB_en_in & ~abort;
        e_mren = MEM_R_EN_in;
        e_alu  = ALU_result_in;
        e_dst  = Dest_in;
        e_rv   = (MEM_R_EN_in & ~MEM_W_EN_in & ack) ? mem_rdata : 32'd0;
      end
      e_err = abort;
    end
    #1;
  endtask

  // ack_at: request cycle (1-based) carrying mem_ack; 0 means never
  task automatic instr(input bit wb, input bit r, input bit w,
                       input logic [31:0] alu, input logic [31:0] st,
                       input logic [4:0] dst, input int ack_at,
                       input logic [31:0] rd);
    int k;
    WB_en_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
    ALU_result_in = alu; ST_val_in = st; Dest_in = dst; mem_rdata = rd;
    if (!(r | w)) begin
      step(0, 0, 0, 0);
    end else if (ALIGN_ON && alu[1:0] != 2'b00) begin
      step(0, 0, 0, 1);
    end else begin
      step(1, 0, 0, 0);
      e_we = w;
      e_addr = alu[ADDR_W+1:2];
      e_wdata = st;
      k = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
      for (int c = 1; c <= k; c++)
        step(c != k, 1, c == ack_at, (c == k) && (c != ack_at));
    end
  endtask

  task automatic nop(input bit ack);
    WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
    ALU_result_in = '0; ST_val_in = '0; Dest_in = '0;
    step(0, 0, ack, 0);
  endtask

  initial begin
    rst = 0;
    nop(0);
    chk = 1;
    nop(0);
    check("rst_mem_req", mem_req, 0);
    check("rst_WB_en", WB_en, 0);
    rst = 1;
    nop(0);

    // ALU op
    frz_seen = 0;
    instr(1, 0, 0, 32'h2A, 0, 5'd3, 0, 0);
    check("t1_WB_en", WB_en, 1);
    check("t1_ALU", ALU_result, 32'h2A);
    check("t1_Dest", Dest, 3);
    check("t1_frz", frz_seen, 0);

    // load, ack on third request cycle
    frz_seen = 0;
    instr(1, 1, 0, 32'h10, 0, 5'd9, 3, 32'hDEADBEEF);
    check("t2_frz", frz_seen, 3);
    check("t2_addr", last_addr, 4);
    check("t2_rv", MEM_read_value, 32'hDEADBEEF);
    check("t2_mren", MEM_R_EN, 1);

    // store, immediate ack
    frz_seen = 0;
    instr(1, 0, 1, 32'h8, 32'h55, 5'd4, 1, 32'hFFFF_FFFF);
    check("t3_frz", frz_seen, 1);
    check("t3_we", last_we, 1);
    check("t3_addr", last_addr, 2);
    check("t3_wdata", last_wdata, 32'h55);
    check("t3_WB_en", WB_en, 1);
    check("t3_rv", MEM_read_value, 0);

    // back-to-back loads
    instr(1, 1, 0, 32'h100, 0, 5'd5, 2, 32'hCAFE0001);
    instr(1, 1, 0, 32'h104, 0, 5'd6, 1, 32'hCAFE0002);
    check("b2b_rv", MEM_read_value, 32'hCAFE0002);
    check("b2b_addr", last_addr, 32'h41);

    // load and store both set: store, load result 0
    instr(1, 1, 1, 32'h20, 32'h77, 5'd8, 2, 32'h999);
    check("both_we", last_we, 1);
    check("both_rv", MEM_read_value, 0);
    nop(0);

    // timeout, then stray ack
    req_seen = 0; err_seen = 0;
    instr(1, 1, 0, 32'h30, 0, 5'd10, 0, 32'hBAD);
    check("t4_WB_en", WB_en, 0);
    nop(1);
    nop(0);
    check("t4_req", req_seen, TIMEOUT);
    check("t4_err", err_seen, 1);

    // reset in second BUSY cycle
    WB_en_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0;
    ALU_result_in = 32'h40; ST_val_in = 0; Dest_in = 5'd7;
    step(1, 0, 0, 0);
    e_we = 0; e_addr = 10'h10; e_wdata = 0;
    step(1, 1, 0, 0);
    rst = 0;
    step(1, 1, 0, 0);
    nop(0);
    check("t5_req", mem_req, 0);
    check("t5_alu", ALU_result, 0);
    check("t5_dest", Dest, 0);
    rst = 1;
    nop(1);
    check("t5_late_ack", mem_req, 0);

    // low address bits set
    req_seen = 0; err_seen = 0;
    instr(1, 1, 0, 32'h13, 0, 5'd11, 2, 32'h1234);
    nop(0);
`ifdef MEM_ALIGN_CHECK_EN
    check("t6_req", req_seen, 0);
    check("t6_err", err_seen, 1);
`else
    check("t6_addr", last_addr, 4);
    check("t6_req", req_seen, 2);
    check("t6_err", err_seen, 0);
`endif
    nop(0);
    nop(0);
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
